// File: rtl/hdr_event_buffer.sv
// hdr_event_buffer
// ----------------
// Event-framed ring buffer for header words, built around a simple dual-port
// RAM. Port A is written by the header builder, port B is read by the readout
// sequencer, and both sides share one clock.
//
// A word becomes visible to the reader only once the word that carries
// wr_last has been written. That word commits the whole event. If the buffer
// fills before the event completes, the rest of the event is swallowed and
// the write pointer rolls back to the last commit point, so the reader never
// sees a truncated event.
//
// Ports:
//   clock              sole clock, rising edge
//   reset_n            synchronous active-low reset
//   wr_en/wr_data      write one word
//   wr_last            this word ends the event
//   wr_full            committed plus pending words fill the RAM
//   rd_en              read request, honoured only while rd_avail=1
//   rd_avail           at least one committed unread word
//   rd_data/rd_last    registered read word and its end-of-event flag
//   rd_valid           one-cycle strobe for rd_data/rd_last
//   nevents            committed events not yet fully read
//   ovf                sticky: an event has been dropped since reset
//   ndrop              saturating dropped-event counter
//   par_err            sticky read parity error
//
// Optional feature (macro HDR_EVENT_PARITY_EN): each word also stores an odd
// parity bit over {last, data}. The bit is checked whenever rd_valid is high.
// When the macro is undefined, par_err is tied low.

module hdr_event_buffer #(
  parameter int RAM_WIDTH = 9,
  parameter int RAM_ADRB  = 11,
  parameter int NDROP_W   = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [RAM_WIDTH-1:0] wr_data,
  input  logic                 wr_last,
  output logic                 wr_full,
  input  logic                 rd_en,
  output logic                 rd_avail,
  output logic [RAM_WIDTH-1:0] rd_data,
  output logic                 rd_last,
  output logic                 rd_valid,
  output logic [RAM_ADRB:0]    nevents,
  output logic                 ovf,
  output logic [NDROP_W-1:0]   ndrop,
  output logic                 par_err
);

  localparam int DEPTH = 1 << RAM_ADRB;
`ifdef HDR_EVENT_PARITY_EN
  localparam int MW = RAM_WIDTH + 2;
`else
  localparam int MW = RAM_WIDTH + 1;
`endif

  localparam logic [RAM_ADRB:0]  PTR_ONE   = {{RAM_ADRB{1'b0}}, 1'b1};
  localparam logic [RAM_ADRB:0]  FULL_CNT  = {1'b1, {RAM_ADRB{1'b0}}};
  localparam logic [NDROP_W-1:0] NDROP_ONE = {{(NDROP_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, FILL, DROP} wrState_e;

  logic [MW-1:0]        mem_q [DEPTH];
  logic                 lastFlag_q [DEPTH];

  wrState_e             wrState_q;
  logic [RAM_ADRB:0]    wrPtr_q;
  logic [RAM_ADRB:0]    cmtPtr_q;
  logic [RAM_ADRB:0]    rdPtr_q;
  logic [RAM_ADRB:0]    nevents_q;
  logic [NDROP_W-1:0]   ndrop_q;
  logic                 ovf_q;
  logic                 rdValid_q;
  logic [RAM_WIDTH-1:0] rdData_q;
  logic                 rdLast_q;

  logic [RAM_ADRB:0]    usedWords;
  logic                 wrAccept;
  logic                 wrCommit;
  logic                 rdAccept;
  logic                 rdIssueLast;
  logic [MW-1:0]        wrWord;
  logic [MW-1:0]        ramWord;

  // Pointer arithmetic wraps naturally. The extra MSB tells full from empty.
  assign usedWords = wrPtr_q - rdPtr_q;
  assign wr_full   = (usedWords == FULL_CNT);
  assign rd_avail  = (cmtPtr_q != rdPtr_q);

  assign wrAccept    = wr_en && (wrState_q != DROP) && !wr_full;
  assign wrCommit    = wrAccept && wr_last;
  assign rdAccept    = rd_en && rd_avail;
  // The event count must drop in the cycle the read is issued, before the RAM
  // word comes back. A small side copy of the last flags provides the flag
  // immediately, so port B stays a plain synchronous read.
  assign rdIssueLast = rdAccept && lastFlag_q[rdPtr_q[RAM_ADRB-1:0]];

`ifdef HDR_EVENT_PARITY_EN
  logic rdPar_q;
  logic parErr_q;
  logic parBad;

  // Odd parity: the stored bit makes the XOR of all stored bits equal to 1.
  assign wrWord  = {~^{wr_last, wr_data}, wr_last, wr_data};
  assign parBad  = rdValid_q && !(^{rdPar_q, rdLast_q, rdData_q});
  assign par_err = parErr_q | parBad;
`else
  assign wrWord  = {wr_last, wr_data};
  assign par_err = 1'b0;
`endif

  assign ramWord = mem_q[rdPtr_q[RAM_ADRB-1:0]];

  // RAM port A. A write and a read can never hit the same address in one
  // cycle, because reads are restricted to committed space.
  always_ff @(posedge clock) begin
    if (reset_n && wrAccept) begin
      mem_q[wrPtr_q[RAM_ADRB-1:0]]      <= wrWord;
      lastFlag_q[wrPtr_q[RAM_ADRB-1:0]] <= wr_last;
    end
  end

  // Write framing FSM, read port B register, and event bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wrState_q <= IDLE;
      wrPtr_q   <= '0;
      cmtPtr_q  <= '0;
      rdPtr_q   <= '0;
      nevents_q <= '0;
      ndrop_q   <= '0;
      ovf_q     <= 1'b0;
      rdValid_q <= 1'b0;
      rdData_q  <= '0;
      rdLast_q  <= 1'b0;
    end else begin
      if (wrAccept) begin
        wrPtr_q <= wrPtr_q + PTR_ONE;
        if (wr_last) begin
          cmtPtr_q  <= wrPtr_q + PTR_ONE;
          wrState_q <= IDLE;
        end else begin
          wrState_q <= FILL;
        end
      end else if (wr_en) begin
        // The buffer is full or the event is already being dropped. The
        // closing word discards the whole partial event.
        if (wr_last) begin
          wrPtr_q   <= cmtPtr_q;
          ovf_q     <= 1'b1;
          wrState_q <= IDLE;
          if (ndrop_q != '1) begin
            ndrop_q <= ndrop_q + NDROP_ONE;
          end
        end else begin
          wrState_q <= DROP;
        end
      end

      rdValid_q <= rdAccept;
      if (rdAccept) begin
        rdPtr_q  <= rdPtr_q + PTR_ONE;
        rdData_q <= ramWord[RAM_WIDTH-1:0];
        rdLast_q <= ramWord[RAM_WIDTH];
      end

      // A commit and a last-word read in the same cycle cancel out.
      if (wrCommit && !rdIssueLast) begin
        nevents_q <= nevents_q + PTR_ONE;
      end else if (!wrCommit && rdIssueLast) begin
        nevents_q <= nevents_q - PTR_ONE;
      end
    end
  end

`ifdef HDR_EVENT_PARITY_EN
  // The stored parity bit travels with the read word and is then checked.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rdPar_q  <= 1'b0;
      parErr_q <= 1'b0;
    end else begin
      if (rdAccept) begin
        rdPar_q <= ramWord[RAM_WIDTH+1];
      end
      if (parBad) begin
        parErr_q <= 1'b1;
      end
    end
  end
`endif

  assign rd_valid = rdValid_q;
  assign rd_data  = rdData_q;
  assign rd_last  = rdLast_q;
  assign nevents  = nevents_q;
  assign ovf      = ovf_q;
  assign ndrop    = ndrop_q;

endmodule

// File: tb/tb_hdr_event_buffer.sv
// Testbench for hdr_event_buffer with RAM_ADRB=4 (16 words).
// The reference model treats the buffer as two queues, committed words and the
// pending event, plus a drop flag and counters.

module tb_hdr_event_buffer;

  localparam int W     = 9;
  localparam int AW    = 4;
  localparam int NW    = 8;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          wr_last;
  logic          wr_full;
  logic          rd_en;
  logic          rd_avail;
  logic [W-1:0]  rd_data;
  logic          rd_last;
  logic          rd_valid;
  logic [AW:0]   nevents;
  logic          ovf;
  logic [NW-1:0] ndrop;
  logic          par_err;

  always #5 clock = ~clock;

  hdr_event_buffer #(.RAM_WIDTH(W), .RAM_ADRB(AW), .NDROP_W(NW)) dut (
    .clock(clock), .reset_n(reset_n),
    .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last), .wr_full(wr_full),
    .rd_en(rd_en), .rd_avail(rd_avail), .rd_data(rd_data), .rd_last(rd_last),
    .rd_valid(rd_valid), .nevents(nevents), .ovf(ovf), .ndrop(ndrop),
    .par_err(par_err)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state
  logic [W:0]   mCommitted[$];
  logic [W:0]   mPending[$];
  bit           mDropping;
  int           mEvents;
  int           mNdrop;
  bit           mOvf;
  bit           mValid;
  logic [W-1:0] mRdData;
  bit           mRdLast;

  typedef struct {
    logic         we;
    logic [W-1:0] wd;
    logic         wl;
    logic         re;
    logic         eValid;
    logic [W-1:0] eData;
    logic         eLast;
    logic         eAvail;
    int           eNev;
    logic         eFull;
  } vec_t;

  vec_t vecs[8];

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic modelStep(input logic we, input logic [W-1:0] wd, input logic wl, input logic re);
    bit availPre;
    bit fullPre;
    logic [W:0] w;
    if (!reset_n) begin
      mCommitted.delete(); mPending.delete();
      mDropping = 0; mEvents = 0; mNdrop = 0; mOvf = 0;
      mValid = 0; mRdData = '0; mRdLast = 0;
    end else begin
      availPre = mCommitted.size() > 0;
      fullPre  = (mCommitted.size() + mPending.size()) == DEPTH;
      mValid = 0;
      if (re && availPre) begin
        w = mCommitted.pop_front();
        mValid = 1; mRdData = w[W-1:0]; mRdLast = w[W];
        if (w[W]) mEvents--;
      end
      if (we) begin
        if (!mDropping && !fullPre) begin
          mPending.push_back({wl, wd});
          if (wl) begin
            foreach (mPending[i]) mCommitted.push_back(mPending[i]);
            mPending.delete();
            mEvents++;
          end
        end else if (wl) begin
          mPending.delete();
          mDropping = 0;
          mOvf = 1;
          if (mNdrop < 255) mNdrop++;
        end else begin
          mDropping = 1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [W-1:0] wd, input logic wl, input logic re);
    wr_en = we; wr_data = wd; wr_last = wl; rd_en = re;
    @(posedge clock);
    modelStep(we, wd, wl, re);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".wr_full"}, 32'(wr_full), 32'((mCommitted.size() + mPending.size()) == DEPTH));
    checkVal({tag, ".rd_avail"}, 32'(rd_avail), 32'(mCommitted.size() > 0));
    checkVal({tag, ".rd_valid"}, 32'(rd_valid), 32'(mValid));
    checkVal({tag, ".rd_data"}, 32'(rd_data), 32'(mRdData));
    if (mValid) checkVal({tag, ".rd_last"}, 32'(rd_last), 32'(mRdLast));
    checkVal({tag, ".nevents"}, 32'(nevents), 32'(mEvents));
    checkVal({tag, ".ovf"}, 32'(ovf), 32'(mOvf));
    checkVal({tag, ".ndrop"}, 32'(ndrop), 32'(mNdrop));
    checkVal({tag, ".par_err"}, 32'(par_err), 32'd0);
  endtask

  task automatic doReset(input logic we, input logic re);
    reset_n = 1'b0;
    applyStimulus(we, 9'h0AA, 1'b0, re);
    checkOutput("reset");
    reset_n = 1'b1;
  endtask

  task automatic writeEvent(input int n, input logic [W-1:0] base, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, base + W'(i), (i == n - 1), 1'b0);
      checkOutput(tag);
    end
  endtask

  task automatic readWords(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput(tag);
    end
  endtask

  initial begin
    // Event A1,A2,A3 followed by three reads and an idle read request
    vecs[0] = '{1, 9'h0A1, 0, 0, 0, 9'h000, 0, 0, 0, 0};
    vecs[1] = '{1, 9'h0A2, 0, 0, 0, 9'h000, 0, 0, 0, 0};
    vecs[2] = '{1, 9'h1A3, 1, 0, 0, 9'h000, 0, 1, 1, 0};
    vecs[3] = '{0, 9'h000, 0, 1, 1, 9'h0A1, 0, 1, 1, 0};
    vecs[4] = '{0, 9'h000, 0, 1, 1, 9'h0A2, 0, 1, 1, 0};
    vecs[5] = '{0, 9'h000, 0, 1, 1, 9'h1A3, 1, 0, 0, 0};
    vecs[6] = '{0, 9'h000, 0, 0, 0, 9'h1A3, 0, 0, 0, 0};
    vecs[7] = '{0, 9'h000, 0, 1, 0, 9'h1A3, 0, 0, 0, 0};

    reset_n = 1'b0; wr_en = 0; wr_data = '0; wr_last = 0; rd_en = 0;
    mValid = 0; mRdData = '0; mRdLast = 0;
    mDropping = 0; mEvents = 0; mNdrop = 0; mOvf = 0;
    repeat (2) @(posedge clock);
    #1;
    doReset(1'b0, 1'b0);

    // Three-word event, table driven
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].we, vecs[i].wd, vecs[i].wl, vecs[i].re);
      checkVal($sformatf("vec%0d.rd_valid", i), 32'(rd_valid), 32'(vecs[i].eValid));
      checkVal($sformatf("vec%0d.rd_data", i), 32'(rd_data), 32'(vecs[i].eData));
      if (vecs[i].eValid) checkVal($sformatf("vec%0d.rd_last", i), 32'(rd_last), 32'(vecs[i].eLast));
      checkVal($sformatf("vec%0d.rd_avail", i), 32'(rd_avail), 32'(vecs[i].eAvail));
      checkVal($sformatf("vec%0d.nevents", i), 32'(nevents), 32'(vecs[i].eNev));
      checkVal($sformatf("vec%0d.wr_full", i), 32'(wr_full), 32'(vecs[i].eFull));
    end

    // Sixteen-word event fills the RAM, then a closing word is dropped
    doReset(1'b0, 1'b0);
    writeEvent(16, 9'h010, "fill16");
    checkVal("fill16.full", 32'(wr_full), 32'd1);
    checkVal("fill16.nevents", 32'(nevents), 32'd1);
    applyStimulus(1'b1, 9'h1FF, 1'b1, 1'b0);
    checkOutput("drop17");
    checkVal("drop17.ndrop", 32'(ndrop), 32'd1);
    checkVal("drop17.ovf", 32'(ovf), 32'd1);
    checkVal("drop17.nevents", 32'(nevents), 32'd1);
    checkVal("drop17.full", 32'(wr_full), 32'd1);
    readWords(16, "drain16");

    // Twelve stored words, an overflowing six-word event, then a fresh event
    doReset(1'b0, 1'b0);
    writeEvent(12, 9'h020, "fill12");
    writeEvent(6, 9'h040, "ovf6");
    checkVal("ovf6.ndrop", 32'(ndrop), 32'd1);
    readWords(12, "read12");
    writeEvent(4, 9'h060, "wrap4");
    checkVal("wrap4.mem12", 32'(dut.mem_q[12][W-1:0]), 32'h060);
    checkVal("wrap4.mem15", 32'(dut.mem_q[15][W-1:0]), 32'h063);
    readWords(5, "read4");

    // Commit in the same cycle as a last-word read
    doReset(1'b0, 1'b0);
    writeEvent(2, 9'h0B0, "evB");
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("readB1");
    applyStimulus(1'b1, 9'h0C0, 1'b1, 1'b1);
    checkOutput("simul");
    checkVal("simul.nevents", 32'(nevents), 32'd1);
    checkVal("simul.data", 32'(rd_data), 32'h0B1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("readC1");
    checkVal("readC1.data", 32'(rd_data), 32'h0C0);
    checkVal("readC1.nevents", 32'(nevents), 32'd0);

    // Drop counter saturation
    writeEvent(16, 9'h100, "satfill");
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1'b1, W'(i), 1'b1, 1'b0);
      checkOutput("sat");
    end
    checkVal("sat.ndrop", 32'(ndrop), 32'd255);
    readWords(16, "satdrain");

    // Reset in the middle of an event with two events stored
    writeEvent(2, 9'h0D0, "ev1");
    writeEvent(1, 9'h0E0, "ev2");
    applyStimulus(1'b1, 9'h0F0, 1'b0, 1'b0);
    checkOutput("partial");
    doReset(1'b1, 1'b1);
    checkVal("midrst.rd_avail", 32'(rd_avail), 32'd0);
    checkVal("midrst.nevents", 32'(nevents), 32'd0);
    checkVal("midrst.ovf", 32'(ovf), 32'd0);
    checkVal("midrst.ndrop", 32'(ndrop), 32'd0);
    checkVal("midrst.rd_data", 32'(rd_data), 32'd0);
    writeEvent(1, 9'h155, "postrst");
    checkVal("postrst.mem0", 32'(dut.mem_q[0][W-1:0]), 32'h155);
    readWords(1, "postrst_rd");

    // Randomised traffic: a filling phase, then a draining phase
    for (int i = 0; i < 3000; i++) begin
      logic we, wl, re;
      we = ($urandom % 4) != 0;
      wl = ($urandom % 5) == 0;
      re = (i < 1500) ? (($urandom % 3) == 0) : (($urandom % 4) != 0);
      reset_n = (($urandom % 700) != 0);
      applyStimulus(we, W'($urandom_range(0, 511)), wl, re);
      checkOutput("rand");
      reset_n = 1'b1;
    end

`ifdef HDR_EVENT_PARITY_EN
    // Corrupt one stored parity bit and read the word back
    doReset(1'b0, 1'b0);
    writeEvent(1, 9'h0F0, "parwr");
    dut.mem_q[0][W+1] = ~dut.mem_q[0][W+1];
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkVal("par.valid", 32'(rd_valid), 32'd1);
    checkVal("par.data", 32'(rd_data), 32'h0F0);
    checkVal("par.err", 32'(par_err), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkVal("par.sticky", 32'(par_err), 32'd1);
    reset_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    reset_n = 1'b1;
    checkVal("par.cleared", 32'(par_err), 32'd0);
`else
    checkVal("par.off", 32'(par_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
